mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_mem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder -- single-port 64-bit word memory slave with fixed read and
// write latencies, power-up zeroing and simple activity/error reporting.
//
// After reset the array is cleared one word per clock (INIT). Once idle, a
// request is captured on the first IDLE edge that sees req high. Its
// address, direction and write data are frozen in internal registers. The
// access completes a fixed number of clocks later with a single rdy pulse.
//
// Parameters
//   ADDR_BITS : log2 of the number of 64-bit words in the array
//   RD_LAT    : clocks from accept to the read rdy cycle (1..15)
//   WR_LAT    : clocks from accept to the write commit edge (1..15)
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-low reset
//   req       : request from initiator, held high until rdy
//   wr        : 1 = write, 0 = read (valid with req)
//   addr      : 64-bit word address (valid with req)
//   wdata     : write data (valid with req and wr)
//   rdata     : read data, held until the next read completes
//   rdy       : one-cycle completion pulse
//   init_done : high once the array clear has finished
//   oor_err   : sticky flag, set by any out-of-range access
//   rd_cnt    : completed reads, wrapping
//   wr_cnt    : completed writes, wrapping
module mem_responder #(
  parameter int ADDR_BITS = 13,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        rdy,
  output logic        init_done,
  output logic        oor_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int         WORDS   = 1 << ADDR_BITS;
  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_WAIT,
    WR_WAIT,
    ACK
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_BITS-1:0]   init_idx;
  logic [3:0]             lat_cnt;
  logic [3:0]             lat_load;
  logic [63:0]            addr_q;
  logic [63:0]            wdata_q;
  logic                   wr_q;
  logic                   accept;
  logic                   in_range;
  logic [ADDR_BITS-1:0]   idx;
  logic [63:0]            mem [WORDS];

  assign accept   = (state == IDLE) && req;
  assign lat_load = wr ? WR_LOAD : RD_LOAD;
  assign in_range = (addr_q >> ADDR_BITS) == 64'd0;
  assign idx      = addr_q[ADDR_BITS-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. ACK is the last latency cycle: the access is performed
  // on the edge leaving ACK, so rdy is visible while the FSM is already back
  // in IDLE. This gives the LAT+1 accept spacing.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
        if (&init_idx) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (req) begin
          if (lat_load == 4'd0) begin
            state_nxt = ACK;
          end else if (wr) begin
            state_nxt = WR_WAIT;
          end else begin
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (lat_cnt == 4'd1) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Datapath. Captures the request, runs the latency counter and produces
  // the completion outputs on the edge that leaves ACK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_idx  <= '0;
      lat_cnt   <= 4'd0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      wr_q      <= 1'b0;
      rdy       <= 1'b0;
      rdata     <= 64'd0;
      init_done <= 1'b0;
      oor_err   <= 1'b0;
      rd_cnt    <= 32'd0;
      wr_cnt    <= 32'd0;
    end else begin
      rdy <= (state == ACK);

      if (state == INIT) begin
        init_idx <= init_idx + 1'b1;
        if (&init_idx) begin
          init_done <= 1'b1;
        end
      end

      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= wr;
        lat_cnt <= lat_load;
      end else if ((state == RD_WAIT) || (state == WR_WAIT)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end

      if (state == ACK) begin
        if (!in_range) begin
          oor_err <= 1'b1;
        end
        if (wr_q) begin
          wr_cnt <= wr_cnt + 32'd1;
        end else begin
          rd_cnt <= rd_cnt + 32'd1;
          rdata  <= in_range ? mem[idx] : 64'd0;
        end
      end
    end
  end

  // Storage array. It has no reset: its contents come only from INIT zeroing
  // and committed in-range writes. While rst is low the FSM sits in INIT at
  // index 0, so a write aborted by reset can never land.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_idx] <= 64'd0;
    end else if ((state == ACK) && wr_q && in_range) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- directed and randomized bench for mem_responder with a
// small ADDR_BITS so that INIT and the address space stay short.
//
// The reference model is transaction-level: an array of words, the expected
// counters and the sticky error flag are updated per completed access.
module tb_mem_responder;

  localparam int AB    = 4;
  localparam int RL    = 2;
  localparam int WL    = 5;
  localparam int WORDS = 1 << AB;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        rdy;
  logic        init_done;
  logic        oor_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int          total = 0;
  int          bad   = 0;

  logic [63:0] model [WORDS];
  int          exp_rd;
  int          exp_wr;
  logic        exp_oor;
  logic [63:0] got;

  mem_responder #(
    .ADDR_BITS(AB),
    .RD_LAT   (RL),
    .WR_LAT   (WL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rdy      (rdy),
    .init_done(init_done),
    .oor_err  (oor_err),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One comparison: counts it, and on a miss counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset for some clocks, check every reset value and clear the model.
  task automatic holdReset(input int cycles);
    rst = 1'b0;
    req = 1'b0;
    wr  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    checkOutput("rst_rdy", 64'(rdy), 64'd0);
    checkOutput("rst_rdata", rdata, 64'd0);
    checkOutput("rst_init_done", 64'(init_done), 64'd0);
    checkOutput("rst_oor", 64'(oor_err), 64'd0);
    checkOutput("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    checkOutput("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    for (int i = 0; i < WORDS; i++) model[i] = 64'd0;
    exp_rd  = 0;
    exp_wr  = 0;
    exp_oor = 1'b0;
  endtask

  // Release reset and count clocks until init_done; no rdy may appear.
  task automatic releaseAndInit();
    int n;
    int pulses;
    n      = 0;
    pulses = 0;
    rst    = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (rdy) pulses++;
      if (init_done) break;
    end
    checkOutput("init_clocks", 64'(n), 64'(WORDS));
    checkOutput("init_no_rdy", 64'(pulses), 64'd0);
  endtask

  // One complete transaction. Inputs are scrambled while it is in flight to
  // show that only the values present at accept matter.
  task automatic applyStimulus(input logic w, input logic [63:0] a,
                               input logic [63:0] d, output logic [63:0] rd_val);
    int          n;
    logic [63:0] exp_data;
    logic        in_rng;
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    n = 0;
    while (!rdy && n < 40) begin
      addr  = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
      wr    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    req    = 1'b0;
    rd_val = rdata;
    in_rng = (a < 64'(WORDS));
    if (!in_rng) exp_oor = 1'b1;
    if (w) begin
      if (in_rng) model[a[AB-1:0]] = d;
      exp_wr++;
      checkOutput("wr_latency", 64'(n), 64'(WL));
    end else begin
      exp_data = in_rng ? model[a[AB-1:0]] : 64'd0;
      exp_rd++;
      checkOutput("rd_latency", 64'(n), 64'(RL));
      checkOutput("rd_data", rdata, exp_data);
    end
    checkOutput("oor_err", 64'(oor_err), 64'(exp_oor));
    checkOutput("rd_cnt", 64'(rd_cnt), 64'(exp_rd));
    checkOutput("wr_cnt", 64'(wr_cnt), 64'(exp_wr));
    @(posedge clk);
    #1;
    checkOutput("rdy_width", 64'(rdy), 64'd0);
  endtask

  // Main directed sequence.
  initial begin
    logic [63:0] q_addr [$];
    logic [63:0] a;
    int          pulses;
    int          span;
    addr  = 64'd0;
    wdata = 64'd0;

    holdReset(3);
    releaseAndInit();

    // First read of a freshly cleared word.
    applyStimulus(1'b0, 64'd5, 64'd0, got);

    // Write then read back the same word with no gap.
    applyStimulus(1'b1, 64'd3, 64'hDEAD_BEEF_0123_4567, got);
    applyStimulus(1'b0, 64'd3, 64'd0, got);
    checkOutput("raw_value", got, 64'hDEAD_BEEF_0123_4567);

    // Random-access read/increment/write loop.
    for (int k = 0; k < 1000; k++) begin
      a = 64'($urandom_range(0, WORDS - 1));
      applyStimulus(1'b0, a, 64'd0, got);
      applyStimulus(1'b1, a, got + 64'd1, got);
    end
    checkOutput("loop_no_oor", 64'(oor_err), 64'd0);

    // req held high: back-to-back reads every RL+1 clocks, address changing
    // every cycle, only the value present on each accept edge counts.
    span   = RL + 1;
    req    = 1'b1;
    wr     = 1'b0;
    addr   = 64'($urandom_range(0, WORDS - 1));
    q_addr.push_back(addr);
    @(posedge clk);
    for (int i = 1; i < 10 * span; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_rdy", 64'(rdy), 64'((i % span) == RL));
      if ((i % span) == RL) begin
        a = q_addr.pop_front();
        exp_rd++;
        checkOutput("hold_rdata", rdata, model[a[AB-1:0]]);
      end
      if (i < 10 * span - 1) begin
        addr = 64'($urandom_range(0, WORDS - 1));
        if (((i + 1) % span) == 0) q_addr.push_back(addr);
      end
    end
    req = 1'b0;
    checkOutput("hold_rd_cnt", 64'(rd_cnt), 64'(exp_rd));

    // Out-of-range write and reads.
    holdReset(2);
    releaseAndInit();
    applyStimulus(1'b1, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, got);
    applyStimulus(1'b0, 64'd0, 64'd0, got);
    applyStimulus(1'b0, 64'hFFFF_0000_0000_0005, 64'd0, got);
    applyStimulus(1'b1, 64'd9, 64'h1234_5678_9ABC_DEF0, got);
    applyStimulus(1'b0, 64'd9, 64'd0, got);

    // Reset two clocks into a write's wait: no completion and no commit.
    holdReset(2);
    releaseAndInit();
    req    = 1'b1;
    wr     = 1'b1;
    addr   = 64'd7;
    wdata  = 64'hA5A5_5A5A_C3C3_3C3C;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    req    = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rdy) pulses++;
    end
    checkOutput("abort_no_rdy", 64'(pulses), 64'd0);
    holdReset(1);
    releaseAndInit();
    checkOutput("abort_wr_cnt", 64'(wr_cnt), 64'd0);
    applyStimulus(1'b0, 64'd7, 64'd0, got);

    // Reset in the middle of INIT restarts the clear from index 0.
    applyStimulus(1'b1, 64'd12, 64'h0BAD_F00D_0000_0001, got);
    holdReset(2);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    holdReset(2);
    releaseAndInit();
    applyStimulus(1'b0, 64'd12, 64'd0, got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
